prim_dev_run_ctrl: RTL and testbench
====================================

# prim_dev_run_ctrl

Run controller for the primitive processor device. It accepts a program-select request, then sequences the device: reset pulse, settle, enable for a bounded run window, and capture of the 32-bit result. It returns the result over a valid/ready response channel. It sits between the board-level switch/button logic (or a host) and the primitive device, and replaces hand-driven `en`/`rst` sequencing.

## Interface
- `SEL_W`, default 3: width of the program-select field (device `SW` input).
- `DATA_W`, default 32: width of the device result (device `HEX` output).
- `RUN_CYCLES`, default 20: number of cycles `dev_en_o` is held high per run; legal range is 1..1023.
- `STABLE_CYCLES`, default 4: consecutive unchanged-result cycles that end a run early. Used only with the macro.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `req_valid_i`, in, 1: run request.
- `req_ready_o`, out, 1: controller idle and able to accept.
- `req_sel_i`, in, `SEL_W`: program select for the run.
- `abort_i`, in, 1: terminate the current run early.
- `dev_rst_o`, out, 1: active-high reset to the device.
- `dev_en_o`, out, 1: device enable.
- `dev_sw_o`, out, `SEL_W`: program select driven to the device.
- `dev_result_i`, in, `DATA_W`: device result.
- `rsp_valid_o`, out, 1: response available.
- `rsp_ready_i`, in, 1: response consumed.
- `rsp_result_o`, out, `DATA_W`: captured result.
- `rsp_cycles_o`, out, 10: number of enabled cycles actually executed.
- `rsp_abort_o`, out, 1: the run ended because of `abort_i`.
- `busy_o`, out, 1: controller not in IDLE.

## Operation
- FSM states: IDLE, RESET, SETTLE, RUN, CAPTURE, RESP. All outputs are registered or decoded from state; there are no combinational paths from input to output.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i && req_ready_o`, latch `req_sel_i` into `dev_sw_o` and go to RESET.
- RESET: `dev_rst_o`=1 for exactly 1 cycle, then SETTLE.
- SETTLE: 1 cycle with `dev_rst_o`=0 and `dev_en_o`=0, then RUN. Clear the run counter.
- RUN:
  - `dev_en_o`=1. The run counter increments each cycle.
  - Exit to CAPTURE when counter reaches `RUN_CYCLES`, or when `abort_i` is 1. `abort_i` has priority over normal completion in the same cycle.
  - `abort_i` outside RUN is ignored.
- CAPTURE:
  - `dev_en_o`=0.
  - Register `dev_result_i` into `rsp_result_o` and the counter value into `rsp_cycles_o`. Set `rsp_abort_o` if the exit was an abort.
  - Go to RESP.
- RESP:
  - `rsp_valid_o`=1. All `rsp_*` fields are held stable until `rsp_valid_o && rsp_ready_i`, then go to IDLE.
  - `req_valid_i` is not accepted in RESP; `req_ready_o`=0.
- `dev_sw_o` holds the last accepted select until the next accept. It is never changed while `dev_en_o`=1.
- `busy_o` = (state != IDLE).

## Timing
- Reset values (while `rst`=0):
  - state IDLE; `req_ready_o`=1.
  - `dev_rst_o`, `dev_en_o`, `rsp_valid_o`, `rsp_abort_o` = 0.
  - `dev_sw_o`, `rsp_result_o`, `rsp_cycles_o` = 0.
- Latency for an accept at edge T:
  - T+1: RESET. T+2: SETTLE.
  - T+3 .. T+2+`RUN_CYCLES`: RUN.
  - T+3+`RUN_CYCLES`: CAPTURE.
  - T+4+`RUN_CYCLES`: `rsp_valid_o`=1. With defaults this is 24 cycles.
- The result sample is taken on the first cycle with `dev_en_o`=0 after RUN.
- If `rsp_ready_i` is already 1 on RESP entry, RESP lasts 1 cycle. The next accept can occur on the following edge.
- Abort asserted in RUN cycle k (1-based): CAPTURE is next and `rsp_cycles_o`=k.
- Reset asserted mid-run: immediate return to IDLE with `dev_en_o`=0. Any pending response is discarded. The device is re-reset by the next run.

## Configuration
- `PRIM_CTRL_EARLY_STOP_EN` defined:
  - In RUN, compare `dev_result_i` with its previous-cycle value. A counter of consecutive equal samples is cleared on any change.
  - When the counter reaches `STABLE_CYCLES`, exit to CAPTURE with `rsp_abort_o`=0.
  - `RUN_CYCLES` remains an upper bound.
- Undefined: no stability logic; RUN always lasts `RUN_CYCLES` unless aborted.

## Test plan
- Reset release, `req_sel_i`=1, `req_valid_i` pulse, model result ramps to 0x2A and then holds, `rsp_ready_i`=1:
  - `dev_rst_o` high for exactly 1 cycle, then `dev_en_o` high for 20 cycles.
  - `rsp_valid_o` at accept+24, with `rsp_result_o`=0x2A, `rsp_cycles_o`=20, `rsp_abort_o`=0.
- `rsp_ready_i`=0 for 5 cycles in RESP: `rsp_*` stable, and `req_ready_o`=0 throughout. A new `req_valid_i` is accepted only after the handshake.
- `abort_i` pulsed in RUN cycle 7: `rsp_cycles_o`=7, `rsp_abort_o`=1, and `dev_en_o` low the next cycle.
- `rst` asserted in RUN cycle 10: `dev_en_o`, `busy_o`, `rsp_valid_o` = 0 immediately and `req_ready_o`=1. No response appears after release.
- Macro defined, result constant from RUN cycle 3: exit after 4 equal samples, so `rsp_cycles_o`=7 and `rsp_abort_o`=0. Macro undefined with the same stimulus: `rsp_cycles_o`=20.
- Back-to-back requests with selects 3 then 5: `dev_sw_o` changes only at accept, and both responses carry the correct captured results.

Source files
------------

// File: rtl/prim_dev_run_ctrl.sv
// Run controller for the primitive processor device: reset pulse, settle, bounded run, capture.
// Optional early stop on a stable result is enabled by defining PRIM_CTRL_EARLY_STOP_EN.
module prim_dev_run_ctrl #(
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RUN_CYCLES    = 20,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [SEL_W-1:0]  req_sel_i,
  input  logic              abort_i,
  output logic              dev_rst_o,
  output logic              dev_en_o,
  output logic [SEL_W-1:0]  dev_sw_o,
  input  logic [DATA_W-1:0] dev_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic [9:0]        rsp_cycles_o,
  output logic              rsp_abort_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StSettle,
    StRun,
    StCapture,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [9:0]        cnt_q, cnt_d;
  logic [9:0]        cnt_inc;
  logic              abort_q, abort_d;
  logic [SEL_W-1:0]  sw_q, sw_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [9:0]        cycles_q, cycles_d;
  logic              rsp_abort_q, rsp_abort_d;
  logic              run_done;
  logic              early_stop;

  // cnt_q holds the number of RUN cycles already completed
  assign cnt_inc  = cnt_q + 10'd1;
  assign run_done = (cnt_inc == 10'(RUN_CYCLES));

`ifdef PRIM_CTRL_EARLY_STOP_EN
  logic [DATA_W-1:0] prev_q;
  logic [9:0]        stable_q, stable_d;
  logic              sample_eq;

  // The first RUN cycle has no in-run predecessor to compare against
  assign sample_eq  = (dev_result_i == prev_q) && (cnt_q != 10'd0);
  assign early_stop = (state_q == StRun) && sample_eq &&
                      ((stable_q + 10'd1) == 10'(STABLE_CYCLES));

  always_comb begin
    stable_d = stable_q;
    if (state_q == StSettle) begin
      stable_d = '0;
    end else if (state_q == StRun) begin
      stable_d = sample_eq ? (stable_q + 10'd1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      prev_q   <= dev_result_i;
      stable_q <= stable_d;
    end
  end
`else
  logic unused_stable_cfg;
  assign unused_stable_cfg = ^10'(STABLE_CYCLES);
  assign early_stop        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      sw_q        <= '0;
      result_q    <= '0;
      cycles_q    <= '0;
      rsp_abort_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      sw_q        <= sw_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
      rsp_abort_q <= rsp_abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    sw_d        = sw_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    rsp_abort_d = rsp_abort_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          sw_d    = req_sel_i;
          state_d = StReset;
        end
      end
      StReset: state_d = StSettle;
      StSettle: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = StCapture;
        end else if (run_done || early_stop) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        result_d    = dev_result_i;
        cycles_d    = cnt_q;
        rsp_abort_d = abort_q;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    dev_rst_o   = 1'b0;
    dev_en_o    = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      StIdle:  req_ready_o = 1'b1;
      StReset: dev_rst_o   = 1'b1;
      StRun:   dev_en_o    = 1'b1;
      StResp:  rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o       = (state_q != StIdle);
  assign dev_sw_o     = sw_q;
  assign rsp_result_o = result_q;
  assign rsp_cycles_o = cycles_q;
  assign rsp_abort_o  = rsp_abort_q;

endmodule

// File: tb/tb_prim_dev_run_ctrl.sv
// Bench for prim_dev_run_ctrl: timeline model of each run plus directed and random traffic.
// Honours PRIM_CTRL_EARLY_STOP_EN the same way as the design.
module tb_prim_dev_run_ctrl;

  localparam int RunCycles    = 20;
  localparam int StableCycles = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_sel;
  logic        abort;
  logic        dev_rst;
  logic        dev_en;
  logic [2:0]  dev_sw;
  logic [31:0] dev_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [9:0]  rsp_cycles;
  logic        rsp_abort;
  logic        busy;

  always #5 clk = ~clk;

  prim_dev_run_ctrl #(
    .SEL_W        (3),
    .DATA_W       (32),
    .RUN_CYCLES   (RunCycles),
    .STABLE_CYCLES(StableCycles)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_sel_i   (req_sel),
    .abort_i     (abort),
    .dev_rst_o   (dev_rst),
    .dev_en_o    (dev_en),
    .dev_sw_o    (dev_sw),
    .dev_result_i(dev_result),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .rsp_cycles_o(rsp_cycles),
    .rsp_abort_o (rsp_abort),
    .busy_o      (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: m_age counts cycles since accept (0 = idle); m_run_len is -1 until the run ends.
  int          m_age;
  int          m_run_len;
  logic        m_pend_abort;
  logic [2:0]  m_sel;
  logic [31:0] m_res;
  int          m_cyc;
  logic        m_abt;
  logic [31:0] hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age        = 0;
    m_run_len    = -1;
    m_pend_abort = 1'b0;
    m_sel        = '0;
    m_res        = '0;
    m_cyc        = 0;
    m_abt        = 1'b0;
    hist.delete();
  endtask

  // True when the last StableCycles+1 in-run samples are all equal
  function automatic bit stable_exit();
`ifdef PRIM_CTRL_EARLY_STOP_EN
    int n;
    n = hist.size();
    if (n < StableCycles + 1) return 1'b0;
    for (int j = n - 1 - StableCycles; j < n - 1; j++) begin
      if (hist[j] != hist[n-1]) return 1'b0;
    end
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    int k;
    if (m_age == 0) begin
      if (req_valid) begin
        m_sel = req_sel;
        m_age = 1;
        hist.delete();
      end
    end else if (m_age < 3) begin
      m_age++;
    end else if (m_run_len < 0) begin
      k = m_age - 2;
      hist.push_back(dev_result);
      if (abort) begin
        m_run_len    = k;
        m_pend_abort = 1'b1;
      end else if (k == RunCycles || stable_exit()) begin
        m_run_len    = k;
        m_pend_abort = 1'b0;
      end
      m_age++;
    end else if (m_age == 3 + m_run_len) begin
      m_res = dev_result;
      m_cyc = m_run_len;
      m_abt = m_pend_abort;
      m_age++;
    end else if (rsp_ready) begin
      m_age     = 0;
      m_run_len = -1;
    end else begin
      m_age++;
    end
  endtask

  always @(negedge clk) begin
    bit in_run, in_resp;
    in_run  = (m_age >= 3) && (m_run_len < 0);
    in_resp = (m_run_len >= 0) && (m_age >= 4 + m_run_len);
    check("req_ready", 32'(req_ready), 32'(m_age == 0));
    check("busy", 32'(busy), 32'(m_age != 0));
    check("dev_rst", 32'(dev_rst), 32'(m_age == 1));
    check("dev_en", 32'(dev_en), 32'(in_run));
    check("rsp_valid", 32'(rsp_valid), 32'(in_resp));
    check("dev_sw", 32'(dev_sw), 32'(m_sel));
    check("rsp_result", rsp_result, m_res);
    check("rsp_cycles", 32'(rsp_cycles), 32'(m_cyc));
    check("rsp_abort", 32'(rsp_abort), 32'(m_abt));
  end

  task automatic tick(input bit v, input logic [2:0] s, input bit ab, input bit rr,
                      input logic [31:0] res);
    req_valid  = v;
    req_sel    = s;
    abort      = ab;
    rsp_ready  = rr;
    dev_result = res;
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  // mode 1: ramp to 0x2A and hold; mode 2: changes until run cycle 2, constant afterwards
  function automatic logic [31:0] res_val(input int mode, input int i, input logic [31:0] base);
    case (mode)
      1:       return (i * 3 > 42) ? 32'd42 : 32'(i * 3);
      2:       return (i <= 4) ? base + 32'(i) : base;
      default: return base;
    endcase
  endfunction

  // Called right after an accept; lat is the cycle index (accept = 0) where rsp_valid shows
  task automatic wait_rsp(input int mode, input logic [31:0] base, input int abort_tick,
                          input bit rr, output int lat, output int n_rst, output int n_en);
    lat   = 0;
    n_rst = 0;
    n_en  = 0;
    for (int i = 1; i <= 80; i++) begin
      if (dev_rst) n_rst++;
      if (dev_en) n_en++;
      if (abort_tick > 0 && i == abort_tick + 1) check("abort_en_low", 32'(dev_en), 32'd0);
      if (rsp_valid) begin
        lat = i;
        break;
      end
      tick($urandom_range(0, 1) == 1, 3'($urandom), (i == abort_tick), rr,
           res_val(mode, i, base));
    end
  endtask

  int lat, n_rst, n_en, n_seen;
  int exp_stable_cycles;

  initial begin
    model_reset();
    req_valid  = 1'b0;
    req_sel    = '0;
    abort      = 1'b0;
    rsp_ready  = 1'b0;
    dev_result = '0;
    rst        = 1'b1;
    #1 rst     = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_dev_en", 32'(dev_en), 32'd0);
    check("rst_dev_rst", 32'(dev_rst), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dev_sw", 32'(dev_sw), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Nominal run with ramping result
    tick(1'b1, 3'd1, 1'b0, 1'b1, 32'd0);
    wait_rsp(1, 32'd0, -1, 1'b1, lat, n_rst, n_en);
    check("nom_latency", 32'(lat), 32'd24);
    check("nom_rst_pulses", 32'(n_rst), 32'd1);
    check("nom_en_cycles", 32'(n_en), 32'd20);
    check("nom_result", rsp_result, 32'h2A);
    check("nom_cycles", 32'(rsp_cycles), 32'd20);
    check("nom_abort", 32'(rsp_abort), 32'd0);
    check("nom_sw", 32'(dev_sw), 32'd1);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);
    check("nom_idle", 32'(req_ready), 32'd1);

    // Response held under backpressure; requests refused until the handshake
    tick(1'b1, 3'd2, 1'b0, 1'b0, 32'hBEEF);
    wait_rsp(0, 32'hBEEF, -1, 1'b0, lat, n_rst, n_en);
    check("hold_latency", 32'(lat), 32'd24);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 3'd6, 1'b0, 1'b0, $urandom);
      check("hold_ready_low", 32'(req_ready), 32'd0);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", rsp_result, 32'hBEEF);
      check("hold_cycles", 32'(rsp_cycles), 32'd20);
    end
    tick(1'b1, 3'd6, 1'b0, 1'b1, 32'd0);
    check("hold_after_hs_ready", 32'(req_ready), 32'd1);
    check("hold_after_hs_sw", 32'(dev_sw), 32'd2);
    tick(1'b1, 3'd6, 1'b0, 1'b1, 32'h66);
    check("hold_accept_sw", 32'(dev_sw), 32'd6);
    check("hold_accept_busy", 32'(busy), 32'd1);
    wait_rsp(0, 32'h66, -1, 1'b1, lat, n_rst, n_en);
    check("hold2_result", rsp_result, 32'h66);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);

    // Abort in run cycle 7 (inputs of run cycle k are driven on tick k+2)
    tick(1'b1, 3'd4, 1'b0, 1'b1, 32'h77);
    wait_rsp(0, 32'h77, 9, 1'b1, lat, n_rst, n_en);
    check("abort_latency", 32'(lat), 32'd11);
    check("abort_en_cycles", 32'(n_en), 32'd7);
    check("abort_cycles", 32'(rsp_cycles), 32'd7);
    check("abort_flag", 32'(rsp_abort), 32'd1);
    check("abort_result", rsp_result, 32'h77);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);

    // Reset in run cycle 10
    tick(1'b1, 3'd5, 1'b0, 1'b1, 32'h55);
    for (int i = 1; i <= 11; i++) tick(1'b0, 3'd0, 1'b0, 1'b1, 32'h55);
    check("mid_en_before", 32'(dev_en), 32'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("mid_en", 32'(dev_en), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_valid", 32'(rsp_valid), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd1);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);
    rst    = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b1, 32'h55);
      if (rsp_valid) n_seen++;
    end
    check("mid_no_rsp", 32'(n_seen), 32'd0);

    // Result constant from run cycle 3
`ifdef PRIM_CTRL_EARLY_STOP_EN
    exp_stable_cycles = 7;
`else
    exp_stable_cycles = 20;
`endif
    tick(1'b1, 3'd3, 1'b0, 1'b1, 32'h100);
    wait_rsp(2, 32'h100, -1, 1'b1, lat, n_rst, n_en);
    check("stable_cycles", 32'(rsp_cycles), 32'(exp_stable_cycles));
    check("stable_latency", 32'(lat), 32'(exp_stable_cycles + 4));
    check("stable_abort", 32'(rsp_abort), 32'd0);
    check("stable_result", rsp_result, 32'h100);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);

    // Back-to-back requests with selects 3 then 5
    tick(1'b1, 3'd3, 1'b0, 1'b1, 32'hA3);
    check("b2b_sw1", 32'(dev_sw), 32'd3);
    wait_rsp(0, 32'hA3, -1, 1'b1, lat, n_rst, n_en);
    check("b2b_result1", rsp_result, 32'hA3);
    tick(1'b1, 3'd5, 1'b0, 1'b1, 32'hA3);
    check("b2b_sw_hs", 32'(dev_sw), 32'd3);
    check("b2b_ready_hs", 32'(req_ready), 32'd1);
    tick(1'b1, 3'd5, 1'b0, 1'b1, 32'hA5);
    check("b2b_sw2", 32'(dev_sw), 32'd5);
    wait_rsp(0, 32'hA5, -1, 1'b1, lat, n_rst, n_en);
    check("b2b_result2", rsp_result, 32'hA5);
    check("b2b_latency2", 32'(lat), 32'd24);
    tick(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, 32'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
